// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
package mc_pkg;

    // Controller states; encodings are visible on the debug state output.
    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11
    } state_e;

    // Instruction class latched in DECODE.
    typedef enum logic [2:0] {
        ClsNone,
        ClsRtype,
        ClsLw,
        ClsSw,
        ClsBeq,
        ClsBne,
        ClsAddi,
        ClsJump
    } class_e;

    // ALU operation codes.
    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOr  = 4'b0011;
    localparam logic [3:0] AluSlt = 4'b0110;

    // Opcodes.
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    // R-type funct codes.
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    // ALU B operand selects.
    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    // Next-PC selects.
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    // Registered (state-decoded) control outputs.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
    } ctrl_t;

    // Control word for a given state; rtype_op is the latched funct mapping.
    function automatic ctrl_t ctrl_for(state_e st, logic [3:0] rtype_op);
        ctrl_t c;
        c        = '0;
        c.alu_op = AluAdd;
        case (st)
            StFetch: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SrcBFour;
                c.pc_source = PcSrcAlu;
            end
            StDecode: c.alu_src_b = SrcBImmSh;
            StMemAdr: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SrcBImm;
            end
            StMemRd: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            StMemWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            StExec: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SrcBReg;
                c.alu_op    = rtype_op;
            end
            StAluWb: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            StBranch: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SrcBReg;
                c.alu_op    = AluSub;
                c.pc_source = PcSrcAluOut;
            end
            StJump:   c.pc_source = PcSrcJump;
            StAddiEx: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SrcBImm;
            end
            StAddiWb: c.reg_write = 1'b1;
            default:  c.alu_op = AluAdd;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control-unit bus: instruction fields and status in, datapath controls out.
interface mc_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       illegal;
    logic [3:0] state;

    // Controller side.
    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal, state
    );

    // Datapath side.
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal, state
    );
endinterface

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation mapping, flagging unsupported funct codes.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       invalid
);

    // Combinational funct lookup; unknown codes fall back to ADD and flag invalid.
    always_comb begin
        alu_op  = AluAdd;
        invalid = 1'b0;
        case (funct)
            FnAdd:   alu_op = AluAdd;
            FnSub:   alu_op = AluSub;
            FnAnd:   alu_op = AluAnd;
            FnOr:    alu_op = AluOr;
            FnSlt:   alu_op = AluSlt;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM. State-decoded controls are registered alongside
// the state; only pc_en, ir_write and illegal are combinational.
module mc_controller
    import mc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input logic             clk,
    input logic             rst_n,
    mc_controller_if.master bus
);

    if (ADDR_W == 0) begin : g_bad_width
        $error("ADDR_W must be non-zero");
    end

    state_e     state_q, state_d;
    class_e     cls_q, cls_d, live_cls;
    logic [3:0] rop_q, rop_d;
    ctrl_t      ctrl_q;
    logic [3:0] dec_op;
    logic       dec_invalid;
    logic       br_take;

    alu_decoder u_alu_decoder (
        .funct   (bus.funct),
        .alu_op  (dec_op),
        .invalid (dec_invalid)
    );

    // Classify the live instruction; only consumed while in DECODE.
    always_comb begin
        live_cls = ClsNone;
        case (bus.opcode)
            OpRtype: live_cls = dec_invalid ? ClsNone : ClsRtype;
            OpLw:    live_cls = ClsLw;
            OpSw:    live_cls = ClsSw;
            OpBeq:   live_cls = ClsBeq;
            OpBne:   live_cls = ClsBne;
            OpAddi:  live_cls = ClsAddi;
            OpJ:     live_cls = ClsJump;
            default: live_cls = ClsNone;
        endcase
    end

    // Next state and latched instruction class.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        rop_d   = rop_q;
        case (state_q)
            StFetch: if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                cls_d = live_cls;
                rop_d = dec_op;
                case (live_cls)
                    ClsLw, ClsSw:   state_d = StMemAdr;
                    ClsRtype:       state_d = StExec;
                    ClsBeq, ClsBne: state_d = StBranch;
                    ClsJump:        state_d = StJump;
                    ClsAddi:        state_d = StAddiEx;
                    default:        state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = (cls_q == ClsSw) ? StMemWr : StMemRd;
            StMemRd:  if (bus.mem_ready) state_d = StMemWb;
            StMemWr:  if (bus.mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            default:  state_d = StFetch;
        endcase
    end

    // State, class and control word; reset aborts mid-instruction and drops strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            cls_q   <= ClsNone;
            rop_q   <= AluAdd;
            ctrl_q  <= ctrl_for(StFetch, AluAdd);
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            rop_q   <= rop_d;
            ctrl_q  <= ctrl_for(state_d, rop_d);
        end
    end

    // Handshake- and flag-dependent outputs.
    always_comb begin
        br_take = 1'b0;
        if (cls_q == ClsBeq) begin
            br_take = bus.zero;
        end else if (cls_q == ClsBne) begin
            br_take = !bus.zero;
        end
        bus.ir_write = (state_q == StFetch) && bus.mem_ready;
        bus.pc_en    = ((state_q == StFetch) && bus.mem_ready) ||
                       (state_q == StJump) ||
                       ((state_q == StBranch) && br_take);
        bus.illegal  = (state_q == StDecode) && (live_cls == ClsNone);
    end

    assign bus.iord       = ctrl_q.iord;
    assign bus.mem_read   = ctrl_q.mem_read;
    assign bus.mem_write  = ctrl_q.mem_write;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.reg_write  = ctrl_q.reg_write;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.pc_source  = ctrl_q.pc_source;
    assign bus.alu_op     = ctrl_q.alu_op;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the driver pushes one expected output
// vector per cycle, a negedge monitor pops and compares.
module tb_mc_controller;
    import mc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    mc_controller_if bus ();

    mc_controller #(
        .ADDR_W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic [3:0] aop;
        logic       ill;
    } obs_t;

    typedef struct {
        string name;
        obs_t  v;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [5:0] nxt_op   = OpRtype;
    logic [5:0] nxt_fn   = FnAdd;
    logic       nxt_z    = 1'b0;
    logic       nxt_rst  = 1'b0;
    exp_t       mon_e;
    obs_t       mon_got;

    // Expected outputs: per-state strobe table plus hand-given alu_op/pc_en/ir_write/illegal.
    function automatic obs_t exp_vec(input logic [3:0] st, input logic [3:0] aop,
                                     input logic pce, input logic irw, input logic ill);
        obs_t v;
        v          = '0;
        v.st       = st;
        v.aop      = aop;
        v.pc_en    = pce;
        v.ir_write = irw;
        v.ill      = ill;
        case (st)
            4'd0:  begin v.mem_read = 1'b1; v.src_b = 2'b01; end
            4'd1:  v.src_b = 2'b11;
            4'd2:  begin v.src_a = 1'b1; v.src_b = 2'b10; end
            4'd3:  begin v.mem_read = 1'b1; v.iord = 1'b1; end
            4'd4:  begin v.reg_write = 1'b1; v.mem_to_reg = 1'b1; end
            4'd5:  begin v.mem_write = 1'b1; v.iord = 1'b1; end
            4'd6:  v.src_a = 1'b1;
            4'd7:  begin v.reg_write = 1'b1; v.reg_dst = 1'b1; end
            4'd8:  begin v.src_a = 1'b1; v.pc_src = 2'b01; end
            4'd9:  v.pc_src = 2'b10;
            4'd10: begin v.src_a = 1'b1; v.src_b = 2'b10; end
            4'd11: v.reg_write = 1'b1;
            default: v = '1;
        endcase
        return v;
    endfunction

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        nxt_op = op;
        nxt_fn = fn;
        nxt_z  = z;
    endtask

    // One cycle: drive inputs just after the edge and queue the expected outputs.
    task automatic step(input string name, input logic rdy, input logic [3:0] st,
                        input logic [3:0] aop, input logic pce, input logic irw,
                        input logic ill);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n         = nxt_rst;
        bus.opcode    = nxt_op;
        bus.funct     = nxt_fn;
        bus.zero      = nxt_z;
        bus.mem_ready = rdy;
        e.name        = name;
        e.v           = exp_vec(st, aop, pce, irw, ill);
        exp_q.push_back(e);
    endtask

    // Monitor: compare every cycle that has a queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {bus.state, bus.pc_en, bus.iord, bus.mem_read, bus.mem_write,
                       bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                       bus.alu_src_a, bus.alu_src_b, bus.pc_source, bus.alu_op,
                       bus.illegal};
            n_checks++;
            if (mon_got === mon_e.v) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got state=%0d vec=%h, want state=%0d vec=%h",
                         mon_e.name, mon_got.st, mon_got, mon_e.v.st, mon_e.v);
            end
        end
    end

    initial begin
        bus.opcode    = OpRtype;
        bus.funct     = FnAdd;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        #1 rst_n = 1'b0;

        // Reset: FETCH values, pc_en/ir_write follow mem_ready.
        step("rst_idle", 1'b0, 4'd0, AluAdd, 1'b0, 1'b0, 1'b0);
        step("rst_rdy",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        nxt_rst = 1'b1;

        instr(OpRtype, FnAdd, 1'b0);
        step("add_f",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("add_d",  1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("add_ex", 1'b1, 4'd6, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("add_wb", 1'b1, 4'd7, AluAdd, 1'b0, 1'b0, 1'b0);

        instr(OpLw, 6'b000000, 1'b0);
        step("lw_f",   1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("lw_d",   1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("lw_ma",  1'b1, 4'd2, AluAdd, 1'b0, 1'b0, 1'b0);
        step("lw_mr0", 1'b0, 4'd3, AluAdd, 1'b0, 1'b0, 1'b0);
        step("lw_mr1", 1'b0, 4'd3, AluAdd, 1'b0, 1'b0, 1'b0);
        step("lw_mr2", 1'b0, 4'd3, AluAdd, 1'b0, 1'b0, 1'b0);
        step("lw_mr3", 1'b1, 4'd3, AluAdd, 1'b0, 1'b0, 1'b0);
        step("lw_wb",  1'b1, 4'd4, AluAdd, 1'b0, 1'b0, 1'b0);

        instr(OpBeq, 6'b000000, 1'b1);
        step("beq_f",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("beq_d",  1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("beq_br", 1'b1, 4'd8, 4'b0001, 1'b1, 1'b0, 1'b0);

        instr(OpBne, 6'b000000, 1'b1);
        step("bne1_f",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("bne1_d",  1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("bne1_br", 1'b1, 4'd8, 4'b0001, 1'b0, 1'b0, 1'b0);

        instr(OpBne, 6'b000000, 1'b0);
        step("bne0_f",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("bne0_d",  1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("bne0_br", 1'b1, 4'd8, 4'b0001, 1'b1, 1'b0, 1'b0);

        instr(OpRtype, FnSlt, 1'b0);
        step("slt_f",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("slt_d",  1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("slt_ex", 1'b1, 4'd6, 4'b0110, 1'b0, 1'b0, 1'b0);
        step("slt_wb", 1'b1, 4'd7, AluAdd, 1'b0, 1'b0, 1'b0);

        instr(OpRtype, FnOr, 1'b0);
        step("or_f",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("or_d",  1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("or_ex", 1'b1, 4'd6, 4'b0011, 1'b0, 1'b0, 1'b0);
        step("or_wb", 1'b1, 4'd7, AluAdd, 1'b0, 1'b0, 1'b0);

        instr(OpRtype, FnSub, 1'b0);
        step("sub_f",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("sub_d",  1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("sub_ex", 1'b1, 4'd6, 4'b0001, 1'b0, 1'b0, 1'b0);
        step("sub_wb", 1'b1, 4'd7, AluAdd, 1'b0, 1'b0, 1'b0);

        instr(6'b111111, 6'b000000, 1'b0);
        step("illop_f", 1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("illop_d", 1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b1);

        instr(OpRtype, 6'b000000, 1'b0);
        step("illfn_f", 1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("illfn_d", 1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b1);

        // addi with one fetch wait state.
        instr(OpAddi, 6'b000000, 1'b0);
        step("addi_fw", 1'b0, 4'd0, AluAdd, 1'b0, 1'b0, 1'b0);
        step("addi_f",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("addi_d",  1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("addi_ex", 1'b1, 4'd10, AluAdd, 1'b0, 1'b0, 1'b0);
        step("addi_wb", 1'b1, 4'd11, AluAdd, 1'b0, 1'b0, 1'b0);

        instr(OpJ, 6'b000000, 1'b0);
        step("j_f", 1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("j_d", 1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("j_j", 1'b1, 4'd9, AluAdd, 1'b1, 1'b0, 1'b0);

        instr(OpSw, 6'b000000, 1'b0);
        step("sw_f",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("sw_d",  1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("sw_ma", 1'b1, 4'd2, AluAdd, 1'b0, 1'b0, 1'b0);
        step("sw_mw", 1'b1, 4'd5, AluAdd, 1'b0, 1'b0, 1'b0);

        // sw stalled in MEMWR, then reset dropped between clock edges.
        step("swr_f",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("swr_d",  1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("swr_ma", 1'b1, 4'd2, AluAdd, 1'b0, 1'b0, 1'b0);
        step("swr_mw", 1'b0, 4'd5, AluAdd, 1'b0, 1'b0, 1'b0);
        nxt_rst = 1'b0;
        step("rst_memwr", 1'b0, 4'd0, AluAdd, 1'b0, 1'b0, 1'b0);
        step("rst_hold",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        nxt_rst = 1'b1;

        instr(OpRtype, FnAnd, 1'b0);
        step("and_f",  1'b1, 4'd0, AluAdd, 1'b1, 1'b1, 1'b0);
        step("and_d",  1'b1, 4'd1, AluAdd, 1'b0, 1'b0, 1'b0);
        step("and_ex", 1'b1, 4'd6, 4'b0010, 1'b0, 1'b0, 1'b0);
        step("and_wb", 1'b1, 4'd7, AluAdd, 1'b0, 1'b0, 1'b0);
        step("end_f",  1'b0, 4'd0, AluAdd, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
